vga_capture: RTL and testbench

Video capture receiver: the input-side counterpart of the VGA display path. Samples an incoming VGA-style stream (hsync, vsync, 12-bit RGB444) at pixel rate, locates the active window from sync edges, and writes one full frame linearly into VRAM port A. Control comes from a register block; the VRAM write port is shared through the VRAM-select mux.

---
 rtl/vga_capture_pkg.sv | 23 ++
 rtl/vga_capture_if.sv | 12 +
 rtl/vga_capture_sync_edge_det.sv | 27 ++
 rtl/vga_capture.sv | 174 +++++++++++++++++
 tb/tb_vga_capture.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture receiver: 640x480 timing defaults,
// VRAM bus widths and the capture FSM state encoding.
package vga_capture_pkg;

   localparam int   DEF_H_ACTIVE = 640;
   localparam int   DEF_V_ACTIVE = 480;
   localparam int   DEF_H_BP     = 48;
   localparam int   DEF_V_BP     = 33;
   localparam logic DEF_SYNC_ACT = 1'b0;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 12;
   localparam int CNT_W  = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_VS = 3'd1,
      ST_WAIT_HS = 3'd2,
      ST_HBP     = 3'd3,
      ST_ACTIVE  = 3'd4
   } cap_state_t;

endpackage

// File: rtl/vga_capture_if.sv
// VRAM port-A write bus driven by the capture block toward the VRAM-select mux.
interface vga_capture_if;
   import vga_capture_pkg::*;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   modport master (output we, output waddr, output wdata);
   modport slave  (input  we, input  waddr, input  wdata);

endinterface

// File: rtl/vga_capture_sync_edge_det.sv
// Sync history register with leading/trailing edge pulses; the pulses are
// combinational against the history so the edge sample itself is flagged.
module sync_edge_det #(
   parameter logic SYNC_ACT = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ce,
   input  logic i_sync,
   output logic o_lead,
   output logic o_trail
);

   logic r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= ~SYNC_ACT;
      end else if (i_ce) begin
         r_q <= i_sync;
      end
   end

   assign o_lead  = i_ce && (i_sync == SYNC_ACT) && (r_q != SYNC_ACT);
   assign o_trail = i_ce && (i_sync != SYNC_ACT) && (r_q == SYNC_ACT);

endmodule

// File: rtl/vga_capture.sv
// Single-frame VGA capture: finds the active window from sync edges and
// writes it linearly into VRAM port A.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no capture; with busy still set, issues frame_done and clears
// ST_WAIT_VS | armed, waiting for vsync trailing edge
// ST_WAIT_HS | counting lines, waiting for hsync trailing edge
// ST_HBP     | inside horizontal back porch of a captured line
// ST_ACTIVE  | writing active pixels of the current line
module vga_capture
   import vga_capture_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_ACT = DEF_SYNC_ACT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_pix_ce,
   input  logic              i_hsync,
   input  logic              i_vsync,
   input  logic [DATA_W-1:0] i_rgb,
   input  logic              i_cap_start,
   input  logic              i_cap_abort,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_frame_err,
   vga_capture_if.master     vram
);

   localparam logic [CNT_W-1:0]  PIX_LAST   = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  HBP_LAST   = CNT_W'(H_BP - 1);
   localparam logic [CNT_W-1:0]  LINE_FIRST = CNT_W'(V_BP);
   localparam logic [CNT_W-1:0]  LINE_END   = CNT_W'(V_BP + V_ACTIVE);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   // A one-pixel back porch means the sample after the edge is already active.
   localparam bit                HBP_SKIP   = (H_BP == 1);

   cap_state_t        r_state;
   logic [CNT_W-1:0]  r_pix;
   logic [CNT_W-1:0]  r_line;
   logic [ADDR_W-1:0] r_wcnt;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic w_hs_trail;
   logic w_hs_lead_unused;
   logic w_vs_trail;
   logic w_vs_lead;
   logic w_err;

   sync_edge_det #(.SYNC_ACT(SYNC_ACT)) u_hs_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_ce    (i_pix_ce),
      .i_sync  (i_hsync),
      .o_lead  (w_hs_lead_unused),
      .o_trail (w_hs_trail)
   );

   sync_edge_det #(.SYNC_ACT(SYNC_ACT)) u_vs_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_ce    (i_pix_ce),
      .i_sync  (i_vsync),
      .o_lead  (w_vs_lead),
      .o_trail (w_vs_trail)
   );

   // Short line (early hsync) or short frame (early vsync) aborts the capture.
   assign w_err = (((r_state == ST_HBP) || (r_state == ST_ACTIVE)) && w_hs_trail)
               || (((r_state == ST_WAIT_HS) || (r_state == ST_HBP) || (r_state == ST_ACTIVE))
                   && w_vs_lead);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_pix   <= '0;
         r_line  <= '0;
         r_wcnt  <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         if (i_cap_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else if (w_err) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (r_busy) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end else if (i_cap_start) begin
                     r_state <= ST_WAIT_VS;
                     r_busy  <= 1'b1;
                     r_err   <= 1'b0;
                     r_wcnt  <= '0;
                     r_waddr <= '0;
                     r_line  <= '0;
                  end
               end
               ST_WAIT_VS: begin
                  if (w_vs_trail) begin
                     r_state <= ST_WAIT_HS;
                     r_line  <= '0;
                  end
               end
               ST_WAIT_HS: begin
                  if (w_hs_trail) begin
                     if ((r_line >= LINE_FIRST) && (r_line < LINE_END)) begin
                        r_state <= HBP_SKIP ? ST_ACTIVE : ST_HBP;
                        r_pix   <= HBP_SKIP ? '0 : CNT_W'(1);
                     end else begin
                        r_line <= r_line + CNT_W'(1);
                     end
                  end
               end
               ST_HBP: begin
                  if (i_pix_ce) begin
                     if (r_pix == HBP_LAST) begin
                        r_state <= ST_ACTIVE;
                        r_pix   <= '0;
                     end else begin
                        r_pix <= r_pix + CNT_W'(1);
                     end
                  end
               end
               ST_ACTIVE: begin
                  if (i_pix_ce) begin
                     r_we    <= 1'b1;
                     r_wdata <= i_rgb;
                     r_waddr <= r_wcnt;
                     r_wcnt  <= r_wcnt + ADDR_W'(1);
                     if (r_wcnt == ADDR_LAST) begin
                        r_state <= ST_IDLE;
                     end else if (r_pix == PIX_LAST) begin
                        r_state <= ST_WAIT_HS;
                        r_line  <= r_line + CNT_W'(1);
                     end else begin
                        r_pix <= r_pix + CNT_W'(1);
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign vram.we      = r_we;
   assign vram.waddr   = r_waddr;
   assign vram.wdata   = r_wdata;
   assign o_busy       = r_busy;
   assign o_frame_done = r_done;
   assign o_frame_err  = r_err;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture at 8x4 active, H_BP=2, V_BP=1: directed frames with a
// write scoreboard checked by an independent monitor.
module tb_vga_capture;

   localparam int HA     = 8;
   localparam int VA     = 4;
   localparam int HBPP   = 2;
   localparam int VBP    = 1;
   localparam int LINE_K = 12;

   logic        clk = 1'b0;
   logic        rst, pix_ce, hs, vs, cap_start, cap_abort;
   logic [11:0] rgb;
   logic        busy, done, err;

   always #5 clk = ~clk;

   vga_capture_if vram();

   vga_capture #(
      .H_ACTIVE (HA),
      .V_ACTIVE (VA),
      .H_BP     (HBPP),
      .V_BP     (VBP),
      .SYNC_ACT (1'b0)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pix_ce     (pix_ce),
      .i_hsync      (hs),
      .i_vsync      (vs),
      .i_rgb        (rgb),
      .i_cap_start  (cap_start),
      .i_cap_abort  (cap_abort),
      .o_busy       (busy),
      .o_frame_done (done),
      .o_frame_err  (err),
      .vram         (vram)
   );

   typedef struct packed {
      logic [18:0] addr;
      logic [11:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   bit          gap_mode = 1'b0;
   bit          prev_we  = 1'b0;
   logic [18:0] prev_addr = '0;
   logic [18:0] exp_addr  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic monitor_step();
      wr_t e;
      if (vram.we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected write: got addr %0d data %0h, required no write",
                     vram.waddr, vram.wdata);
         end else begin
            e = exp_q.pop_front();
            check("write addr", 32'(vram.waddr), 32'(e.addr));
            check("write data", 32'(vram.wdata), 32'(e.data));
         end
         if (gap_mode) check("we back-to-back", 32'(prev_we), 32'(0));
      end
      if (done === 1'b1) begin
         check("done follows last write", 32'({prev_we, prev_addr}), 32'({1'b1, 19'(HA*VA-1)}));
         check("busy low with done", 32'(busy), 32'(0));
         done_cnt++;
      end
      prev_we   = (vram.we === 1'b1);
      prev_addr = vram.waddr;
   endtask

   always @(negedge clk) monitor_step();

   task automatic smp(input bit h, input bit v, input logic [11:0] d, input bit gap);
      @(negedge clk);
      cap_start = 1'b0; cap_abort = 1'b0; rst = 1'b0;
      if (gap) begin
         pix_ce = 1'b0; rgb = 12'hBAD;
         @(negedge clk);
      end
      pix_ce = 1'b1; hs = h; vs = v; rgb = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cap_start = 1'b0; cap_abort = 1'b0; rst = 1'b0;
         pix_ce = 1'b0; rgb = 12'hBAD;
      end
   endtask

   task automatic start();
      @(negedge clk);
      pix_ce = 1'b0; cap_abort = 1'b0; rst = 1'b0; cap_start = 1'b1;
      @(negedge clk);
      cap_start = 1'b0;
      check("busy after start", 32'(busy), 32'(1));
      check("err cleared by start", 32'(err), 32'(0));
      exp_addr = '0;
   endtask

   task automatic push(input logic [11:0] d);
      exp_q.push_back({exp_addr, d});
      exp_addr++;
   endtask

   // kind: 0 clean, 1 early hsync, 2 early vsync, 3 abort+start, 4 start-while-busy then reset
   task automatic run_frame(input int kind, input bit gap);
      logic [11:0] d;
      int          a;
      bit          act;
      gap_mode = gap;
      smp(1'b1, 1'b0, 12'hEEE, gap);
      smp(1'b1, 1'b0, 12'hEEE, gap);
      for (int ln = 0; ln <= VBP + VA; ln++) begin
         a = ln - VBP;
         smp(1'b0, 1'b1, 12'hEEE, gap);
         smp(1'b0, 1'b1, 12'hEEE, gap);
         for (int k = 0; k < LINE_K; k++) begin
            act = (a >= 0) && (a < VA) && (k >= HBPP) && (k < HBPP + HA);
            d   = act ? 12'(a * HA + k - HBPP) : 12'hEEE;
            if (kind == 1 && a == 2 && k == HBPP + 5) begin
               smp(1'b1, 1'b1, d, gap);
               @(negedge clk);
               pix_ce = 1'b0;
               check("hs err busy", 32'(busy), 32'(0));
               check("hs err flag", 32'(err), 32'(1));
               return;
            end
            smp(!(kind == 1 && a == 2 && k == HBPP + 4), 1'b1, d, gap);
            if (kind == 3 && a == 1 && k == HBPP + 3) begin
               cap_abort = 1'b1; cap_start = 1'b1;
               @(negedge clk);
               cap_abort = 1'b0; cap_start = 1'b0; pix_ce = 1'b0;
               check("abort busy", 32'(busy), 32'(0));
               check("abort we", 32'(vram.we), 32'(0));
               check("abort err kept", 32'(err), 32'(0));
               return;
            end
            if (kind == 4 && a == 2 && k == HBPP + 2) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0; pix_ce = 1'b0;
               check("rst busy", 32'(busy), 32'(0));
               check("rst done", 32'(done), 32'(0));
               check("rst err", 32'(err), 32'(0));
               check("rst we", 32'(vram.we), 32'(0));
               check("rst waddr", 32'(vram.waddr), 32'(0));
               check("rst wdata", 32'(vram.wdata), 32'(0));
               return;
            end
            if (act) push(d);
            if (kind == 4 && a == 1 && k == HBPP + 1) cap_start = 1'b1;
         end
         if (kind == 2 && a == 2) begin
            smp(1'b1, 1'b0, 12'hEEE, gap);
            @(negedge clk);
            pix_ce = 1'b0;
            check("vs err busy", 32'(busy), 32'(0));
            check("vs err flag", 32'(err), 32'(1));
            return;
         end
      end
   endtask

   task automatic end_checks(input string tag, input int req_done, input bit req_err);
      idle(4);
      check({tag, " queue drained"}, 32'(exp_q.size()), 32'(0));
      check({tag, " done count"}, 32'(done_cnt), 32'(req_done));
      check({tag, " err"}, 32'(err), 32'(req_err));
      check({tag, " busy"}, 32'(busy), 32'(0));
      exp_q.delete();
      gap_mode = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pix_ce = 1'b0; hs = 1'b1; vs = 1'b1; rgb = '0;
      cap_start = 1'b0; cap_abort = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset err", 32'(err), 32'(0));
      check("reset we", 32'(vram.we), 32'(0));
      check("reset waddr", 32'(vram.waddr), 32'(0));
      check("reset wdata", 32'(vram.wdata), 32'(0));

      start(); run_frame(0, 1'b0); end_checks("clean", 1, 1'b0);
      start(); run_frame(0, 1'b1); end_checks("gapped", 2, 1'b0);
      start(); run_frame(1, 1'b0); end_checks("hs early", 2, 1'b1);

      // abort while idle keeps the sticky error; abort beats a same-cycle start
      @(negedge clk); cap_abort = 1'b1;
      @(negedge clk); cap_abort = 1'b0;
      check("idle abort err kept", 32'(err), 32'(1));
      cap_abort = 1'b1; cap_start = 1'b1;
      @(negedge clk); cap_abort = 1'b0; cap_start = 1'b0;
      check("abort beats start busy", 32'(busy), 32'(0));
      check("abort beats start err", 32'(err), 32'(1));

      start(); run_frame(3, 1'b0); end_checks("abort", 2, 1'b0);
      start(); run_frame(4, 1'b0); end_checks("reset mid", 2, 1'b0);
      start(); run_frame(0, 1'b0); end_checks("after reset", 3, 1'b0);
      start(); run_frame(2, 1'b0); end_checks("vs early", 3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
